// File: rtl/reset_sequencer.sv
// Staged reset release for the divided-clock datapath: div_rst_n first, then core_rst_n.
// Optional watchdog trigger is compiled in with `define RST_WATCHDOG_EN.
module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int DIV_HOLD_CYCLES  = 8,
    parameter int CORE_HOLD_CYCLES = 32,
    parameter int WDT_CYCLES       = 1048576
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       btn_rst_n,
    input  logic       sw_rst_req,
`ifdef RST_WATCHDOG_EN
    input  logic       wdt_kick,
`endif
    output logic       div_rst_n,
    output logic       core_rst_n,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    localparam int SEQ_MAX = (DIV_HOLD_CYCLES > CORE_HOLD_CYCLES) ? DIV_HOLD_CYCLES : CORE_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(SEQ_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    // ASSERT sees DIV_HOLD_CYCLES+1 edges because its entry edge is the trigger edge itself.
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    generate
        if (DEBOUNCE_CYCLES < 2)  begin : g_bad_debounce  $error("DEBOUNCE_CYCLES must be >= 2");  end
        if (DIV_HOLD_CYCLES < 1)  begin : g_bad_div_hold  $error("DIV_HOLD_CYCLES must be >= 1");  end
        if (CORE_HOLD_CYCLES < 4) begin : g_bad_core_hold $error("CORE_HOLD_CYCLES must be >= 4"); end
        if (WDT_CYCLES < 2)       begin : g_bad_wdt       $error("WDT_CYCLES must be >= 2");       end
    endgenerate

    typedef enum logic [1:0] {
        HOLD,
        ASSERT,
        REL_DIV,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        cause_next;

    logic              btn_s1;
    logic              btn_s2;
    logic [DEB_W-1:0]  deb_cnt;
    logic              btn_trig;
    logic              sw_pend;
    logic              sw_hit;
    logic              wdt_hit;

    // Button synchronizer and debounce counter
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
            deb_cnt <= '0;
        end else begin
            btn_s1 <= btn_rst_n;
            btn_s2 <= btn_s1;
            if (btn_s2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign btn_trig = (deb_cnt == DEB_LAST);

    // Software request is registered, so it acts one edge after it is sampled.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sw_pend <= 1'b0;
        end else begin
            sw_pend <= sw_rst_req && (state == RUN);
        end
    end

    assign sw_hit = sw_pend && (state == RUN);

`ifdef RST_WATCHDOG_EN
    localparam int               WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            wdt_cnt <= WDT_LOAD;
        end else if (wdt_kick || (state_next == RUN && state != RUN)) begin
            wdt_cnt <= WDT_LOAD;
        end else if (state == RUN && wdt_cnt != '0) begin
            wdt_cnt <= wdt_cnt - WDT_W'(1);
        end
    end

    // Fire on the edge where the count would reach zero; a kick in that cycle still wins.
    assign wdt_hit = (state == RUN) && !wdt_kick && (wdt_cnt <= WDT_W'(1));
`else
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        cause_next = rst_cause;

        case (state)
            HOLD: begin
                if (!btn_trig) begin
                    state_next = ASSERT;
                    cnt_next   = '0;
                end
            end
            ASSERT: begin
                if (cnt == DIV_LAST) begin
                    state_next = REL_DIV;
                    cnt_next   = '0;
                end
            end
            REL_DIV: begin
                if (cnt == CORE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = ASSERT;
                cnt_next   = '0;
            end
        endcase

        // Trigger priority: button, then watchdog, then software.
        if (btn_trig) begin
            state_next = HOLD;
            cnt_next   = '0;
            cause_next = CAUSE_BTN;
        end else if (wdt_hit) begin
            state_next = ASSERT;
            cnt_next   = '0;
            cause_next = CAUSE_WDT;
        end else if (sw_hit) begin
            state_next = ASSERT;
            cnt_next   = '0;
            cause_next = CAUSE_SW;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= ASSERT;
            cnt        <= '0;
            rst_cause  <= CAUSE_POR;
            div_rst_n  <= 1'b0;
            core_rst_n <= 1'b0;
            seq_busy   <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            rst_cause  <= cause_next;
            div_rst_n  <= (state_next == REL_DIV) || (state_next == RUN);
            core_rst_n <= (state_next == RUN);
            seq_busy   <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, software, button, simultaneous and mid-sequence resets.
// The watchdog scenario is included when RST_WATCHDOG_EN is defined.
module tb_reset_sequencer;

`ifdef RST_WATCHDOG_EN
    localparam int TB_WDT = 100;
`else
    localparam int TB_WDT = 1048576;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       btn_rst_n;
    logic       sw_rst_req;
`ifdef RST_WATCHDOG_EN
    logic       wdt_kick;
`endif
    logic       div_rst_n;
    logic       core_rst_n;
    logic [1:0] rst_cause;
    logic       seq_busy;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .DEBOUNCE_CYCLES (16),
        .DIV_HOLD_CYCLES (8),
        .CORE_HOLD_CYCLES(32),
        .WDT_CYCLES      (TB_WDT)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .btn_rst_n (btn_rst_n),
        .sw_rst_req(sw_rst_req),
`ifdef RST_WATCHDOG_EN
        .wdt_kick  (wdt_kick),
`endif
        .div_rst_n (div_rst_n),
        .core_rst_n(core_rst_n),
        .rst_cause (rst_cause),
        .seq_busy  (seq_busy)
    );

    always #4 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Index i of the loop is the (i+1)-th edge from now; records first rise of each reset.
    task automatic measure(input int limit, output int div_rise, output int core_rise, output int div_fall);
        div_rise  = -1;
        core_rise = -1;
        div_fall  = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (div_rst_n === 1'b1 && div_rise < 0) div_rise = i;
            if (div_rise >= 0 && div_rst_n !== 1'b1 && div_fall < 0) div_fall = i;
            if (core_rst_n === 1'b1 && core_rise < 0) core_rise = i;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (div_rst_n !== 1'b0) begin errors++; $display("FAIL reset_div: got %b expected 0", div_rst_n); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core: got %b expected 0", core_rst_n); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", seq_busy); end
        checks++; if (rst_cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", rst_cause); end
    endtask

    task automatic test_power_on;
        int dr, cr, df;
        rst_n = 1'b1;
        measure(60, dr, cr, df);
        checks++; if (dr !== 8) begin errors++; $display("FAIL por_div_rise: got E0+%0d expected E0+8", dr); end
        checks++; if (cr !== 40) begin errors++; $display("FAIL por_core_rise: got E0+%0d expected E0+40", cr); end
        checks++; if (df !== -1) begin errors++; $display("FAIL por_div_glitch: fell at %0d expected never", df); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL por_busy: got %b expected 0", seq_busy); end
        checks++; if (rst_cause !== 2'b00) begin errors++; $display("FAIL por_cause: got %b expected 00", rst_cause); end
    endtask

    task automatic test_sw_reset;
        int dr, cr, df;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        checks++; if (div_rst_n !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL sw_early: got div=%b core=%b expected 1 1", div_rst_n, core_rst_n); end
        tick();
        checks++; if (div_rst_n !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL sw_assert: got div=%b core=%b expected 0 0", div_rst_n, core_rst_n); end
        checks++; if (rst_cause !== 2'b10) begin errors++; $display("FAIL sw_cause: got %b expected 10", rst_cause); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", seq_busy); end
        dr = -1; cr = -1; df = -1;
        for (int i = 0; i < 50; i++) begin
            sw_rst_req = (i == 15);
            tick();
            if (div_rst_n === 1'b1 && dr < 0) dr = i;
            if (dr >= 0 && div_rst_n !== 1'b1 && df < 0) df = i;
            if (core_rst_n === 1'b1 && cr < 0) cr = i;
        end
        sw_rst_req = 1'b0;
        checks++; if (dr !== 8) begin errors++; $display("FAIL sw_div_rise: got +%0d expected +8", dr); end
        checks++; if (cr !== 40) begin errors++; $display("FAIL sw_core_rise: got +%0d expected +40", cr); end
        checks++; if (df !== -1) begin errors++; $display("FAIL sw_ignored_in_rel_div: div fell at %0d expected never", df); end
        checks++; if (rst_cause !== 2'b10) begin errors++; $display("FAIL sw_cause_after: got %b expected 10", rst_cause); end
    endtask

    task automatic test_button_bounce;
        int dr, cr, df;
        int early;
        btn_rst_n = 1'b0;
        repeat (10) tick();
        btn_rst_n = 1'b1;
        tick();
        btn_rst_n = 1'b0;
        early = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (core_rst_n !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL btn_early: got %0d early low cycles expected 0", early); end
        tick();
        checks++; if (div_rst_n !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL btn_assert: got div=%b core=%b expected 0 0", div_rst_n, core_rst_n); end
        checks++; if (rst_cause !== 2'b01) begin errors++; $display("FAIL btn_cause: got %b expected 01", rst_cause); end
        repeat (25) tick();
        checks++; if (div_rst_n !== 1'b0) begin errors++; $display("FAIL btn_hold: got div=%b expected 0", div_rst_n); end
        btn_rst_n = 1'b1;
        measure(60, dr, cr, df);
        checks++; if (dr !== 12) begin errors++; $display("FAIL btn_div_rise: got +%0d expected +12", dr); end
        checks++; if (cr !== 44) begin errors++; $display("FAIL btn_core_rise: got +%0d expected +44", cr); end
        checks++; if (rst_cause !== 2'b01) begin errors++; $display("FAIL btn_cause_after: got %b expected 01", rst_cause); end
    endtask

    task automatic test_simultaneous;
        int dr, cr, df;
        btn_rst_n = 1'b0;
        repeat (17) tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        tick();
        checks++; if (rst_cause !== 2'b01) begin errors++; $display("FAIL simul_cause: got %b expected 01", rst_cause); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL simul_core: got %b expected 0", core_rst_n); end
        repeat (15) tick();
        checks++; if (div_rst_n !== 1'b0) begin errors++; $display("FAIL simul_hold: got div=%b expected 0", div_rst_n); end
        btn_rst_n = 1'b1;
        measure(20, dr, cr, df);
        checks++; if (dr !== 12) begin errors++; $display("FAIL simul_div_rise: got +%0d expected +12", dr); end
    endtask

    task automatic test_rst_mid_rel_div;
        int dr, cr, df;
        checks++; if (div_rst_n !== 1'b1 || core_rst_n !== 1'b0) begin errors++; $display("FAIL mid_pre_state: got div=%b core=%b expected 1 0", div_rst_n, core_rst_n); end
        rst_n = 1'b0;
        tick();
        checks++; if (div_rst_n !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL mid_resets: got div=%b core=%b expected 0 0", div_rst_n, core_rst_n); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", seq_busy); end
        checks++; if (rst_cause !== 2'b00) begin errors++; $display("FAIL mid_cause: got %b expected 00", rst_cause); end
        rst_n = 1'b1;
        measure(60, dr, cr, df);
        checks++; if (dr !== 8) begin errors++; $display("FAIL mid_div_rise: got E0+%0d expected E0+8", dr); end
        checks++; if (cr !== 40) begin errors++; $display("FAIL mid_core_rise: got E0+%0d expected E0+40", cr); end
    endtask

`ifdef RST_WATCHDOG_EN
    task automatic test_watchdog;
        int lows;
        lows = 0;
        for (int k = 0; k < 6; k++) begin
            wdt_kick = 1'b1;
            tick();
            wdt_kick = 1'b0;
            for (int j = 0; j < 49; j++) begin
                tick();
                if (core_rst_n !== 1'b1) lows++;
            end
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL wdt_kicked: got %0d low cycles expected 0", lows); end
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        repeat (99) tick();
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL wdt_early: got core=%b expected 1", core_rst_n); end
        tick();
        checks++; if (core_rst_n !== 1'b0 || div_rst_n !== 1'b0) begin errors++; $display("FAIL wdt_fire: got div=%b core=%b expected 0 0", div_rst_n, core_rst_n); end
        checks++; if (rst_cause !== 2'b11) begin errors++; $display("FAIL wdt_cause: got %b expected 11", rst_cause); end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        btn_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
`ifdef RST_WATCHDOG_EN
        wdt_kick   = 1'b0;
`endif
        test_reset();
        test_power_on();
        test_sw_reset();
        test_button_bounce();
        test_simultaneous();
        test_rst_mid_rel_div();
`ifdef RST_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
